// File: rtl/sensor_block_packer.sv
// -----------------------------------------------------------------------------
// sensor_block_packer
//
// Packs consecutive 8-bit sensor samples into a 128-bit block for the AES input
// stage. The first sample of a block lands in [127:120], the next in [119:112],
// and so on. Slots that are never written read as zero. This covers a block
// shorter than 16 bytes as well as a block closed early by a flush.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. Once valid is raised, the sender holds valid
// and its data stable until that transfer happens. Ready may change freely.
//
// Ports:
//   clk, rst_n     system clock (rising edge); asynchronous active-low reset
//   sample_in      8-bit sensor sample
//   sample_valid   sample_in is valid this cycle
//   sample_ready   packer accepts a sample this cycle (high while filling)
//   flush          single-cycle request to close a partial block (zero padded)
//   block_out      packed block, first sample in [127:120]
//   block_valid    block_out is valid (high while holding a finished block)
//   block_ready    downstream accepts the block
//   blk_cnt        number of blocks handed off, wraps at 2^CNT_W
//   seq_err        sticky sequence error from the optional checker
//
// Optional build macro: SEQ_CHECK_EN
//   When defined, each accepted sample is compared with the previous accepted
//   sample plus 1 (mod 256). seq_err is set on the first mismatch and stays set
//   until reset. When the macro is undefined, seq_err is tied low.
// -----------------------------------------------------------------------------
module sensor_block_packer #(
  parameter int BYTES_PER_BLOCK = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             flush,
  output logic [127:0]     block_out,
  output logic             block_valid,
  input  logic             block_ready,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             seq_err
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLOCK - 1);

  state_e             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic [127:0]       block_q, block_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         slot_lo;
  logic               accept;
  logic               handoff;

  assign sample_ready = (state_q == S_FILL);
  assign block_valid  = (state_q == S_HOLD);
  assign block_out    = block_q;
  assign blk_cnt      = cnt_q;

  assign accept  = sample_valid & sample_ready;
  assign handoff = block_valid & block_ready;

  // Byte slot idx occupies bits [127-8*idx -: 8], which is the same as [8*(15-idx) +: 8].
  assign slot_lo = {4'd15 - idx_q, 3'b000};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FILL: begin
        if (accept) begin
          block_d[slot_lo +: 8] = sample_in;
          idx_d                 = idx_q + 4'd1;
          // A flush that arrives with the final byte adds nothing. A flush that
          // arrives with an earlier byte closes the block early. Either way the
          // block goes to HOLD.
          if ((idx_q == LAST_IDX) || flush) begin
            state_d = S_HOLD;
          end
        end else if (flush && (idx_q != 4'd0)) begin
          // Unfilled slots are already zero because the register is cleared on handoff.
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (handoff) begin
          state_d = S_FILL;
          idx_d   = 4'd0;
          block_d = '0;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      idx_q   <= 4'd0;
      block_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      block_q <= block_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [7:0] prev_q;
  logic       prev_vld_q;
  logic       err_q;

  // Only accepted samples are checked. Flush padding is never accepted, so it
  // never enters the check. The first accept after reset only loads prev_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 8'd0;
      prev_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      prev_q     <= sample_in;
      prev_vld_q <= 1'b1;
      if (prev_vld_q && (sample_in != (prev_q + 8'd1))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign seq_err = err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_block_packer.sv
// -----------------------------------------------------------------------------
// tb_sensor_block_packer
//
// Bench for sensor_block_packer with default parameters (16 bytes per block,
// 16-bit block counter).
//
// The reference model tracks the accepted bytes in a queue. When a block is
// complete, or when a flush closes a partial block, it packs the bytes into a
// 128-bit word and pushes that word onto exp_q.
//
// A compare process runs on every falling edge. It checks the DUT's handshake
// outputs, the block counter and seq_err against the model. It also checks
// block_out against the head of exp_q, and pops that entry on a handoff.
//
// Directed sections use hand-computed literal blocks. A randomized section
// follows them.
// -----------------------------------------------------------------------------
module tb_sensor_block_packer;

  localparam int BPB = 16;

  logic         clk;
  logic         rst_n;
  logic [7:0]   sample_in;
  logic         sample_valid;
  logic         sample_ready;
  logic         flush;
  logic [127:0] block_out;
  logic         block_valid;
  logic         block_ready;
  logic [15:0]  blk_cnt;
  logic         seq_err;

  sensor_block_packer #(.BYTES_PER_BLOCK(BPB), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .flush        (flush),
    .block_out    (block_out),
    .block_valid  (block_valid),
    .block_ready  (block_ready),
    .blk_cnt      (blk_cnt),
    .seq_err      (seq_err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   pend[$];     // bytes accepted into the current block
  logic [127:0] exp_q[$];    // finished blocks awaiting handoff
  bit           m_holding;
  logic [15:0]  m_cnt;
  bit           m_have_prev;
  logic [7:0]   m_prev;
  bit           m_err;

  function automatic logic [127:0] pack(input logic [7:0] b[$]);
    logic [127:0] r;
    r = '0;
    foreach (b[i]) r[127 - 8*i -: 8] = b[i];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      exp_q.delete();
      m_holding   = 0;
      m_cnt       = '0;
      m_have_prev = 0;
      m_prev      = '0;
      m_err       = 0;
    end else if (m_holding) begin
      if (block_ready) begin
        m_holding = 0;
        m_cnt     = m_cnt + 16'd1;
      end
    end else begin
      if (sample_valid) begin
        pend.push_back(sample_in);
        if (m_have_prev && (sample_in != 8'(m_prev + 8'd1))) m_err = 1;
        m_prev      = sample_in;
        m_have_prev = 1;
        if (pend.size() == BPB || flush) begin
          exp_q.push_back(pack(pend));
          pend.delete();
          m_holding = 1;
        end
      end else if (flush && pend.size() > 0) begin
        exp_q.push_back(pack(pend));
        pend.delete();
        m_holding = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("block_valid", {127'd0, block_valid}, {127'd0, m_holding});
      check("sample_ready", {127'd0, sample_ready}, {127'd0, !m_holding});
      check("blk_cnt", {112'd0, blk_cnt}, {112'd0, m_cnt});
`ifdef SEQ_CHECK_EN
      check("seq_err", {127'd0, seq_err}, {127'd0, m_err});
`else
      check("seq_err", {127'd0, seq_err}, 128'd0);
`endif
      if (m_holding && block_valid) begin
        if (exp_q.size() == 0) begin
          check("exp_q_nonempty", 128'd0, 128'd1);
        end else begin
          check("block_out", block_out, exp_q[0]);
          if (block_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sync();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    flush        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Present one byte and keep it until the packer takes it.
  task automatic send_byte(input logic [7:0] b, input logic fl);
    bit acc;
    int guard;
    sample_in    = b;
    sample_valid = 1'b1;
    flush        = fl;
    guard        = 0;
    forever begin
      @(negedge clk);
      acc = sample_ready;
      sync();
      if (acc) break;
      guard++;
      if (guard > 200) begin
        check("send_timeout", 128'd0, 128'd1);
        break;
      end
    end
    sample_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic send_run(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) send_byte(8'(start + 8'(i)), 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit         acc;
    logic [7:0] nb;
    rst_n        = 1'b0;
    sample_in    = 8'd0;
    sample_valid = 1'b0;
    flush        = 1'b0;
    block_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_block_valid", {127'd0, block_valid}, 128'd0);
    check("rst_sample_ready", {127'd0, sample_ready}, 128'd1);
    check("rst_block_out", block_out, 128'd0);
    check("rst_blk_cnt", {112'd0, blk_cnt}, 128'd0);
    sync();

    // Full block streamed with block_ready high
    send_run(8'h00, 16);
    @(negedge clk);
    check("t1_block", block_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("t1_valid", {127'd0, block_valid}, 128'd1);
    check("t1_ready_low", {127'd0, sample_ready}, 128'd0);
    @(negedge clk);
    check("t1_valid_drop", {127'd0, block_valid}, 128'd0);
    check("t1_cnt", {112'd0, blk_cnt}, 128'd1);
    sync();

    // Backpressure: block stays held, and the 17th sample waits
    block_ready = 1'b0;
    send_run(8'h20, 16);
    sample_in    = 8'h30;
    sample_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("t2_ready_low", {127'd0, sample_ready}, 128'd0);
      check("t2_stable", block_out, 128'h202122232425262728292A2B2C2D2E2F);
    end
    @(posedge clk);
    #1;
    block_ready = 1'b1;
    send_run(8'h30, 16);
    @(negedge clk);
    check("t2_next_block", block_out, 128'h303132333435363738393A3B3C3D3E3F);
    sync();

    // Flush of a partial block, then a flush with nothing buffered
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    flush = 1'b1;
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("t3_flush_block", block_out, {24'hA1A2A3, 104'd0});
    check("t3_flush_valid", {127'd0, block_valid}, 128'd1);
    sync();
    flush = 1'b1;
    sync();
    flush = 1'b0;
    @(negedge clk);
    check("t3_empty_flush", {127'd0, block_valid}, 128'd0);
    sync();

    // Flush in the same cycle as the 5th accept
    send_run(8'h01, 4);
    send_byte(8'h05, 1'b1);
    @(negedge clk);
    check("t4_flush_accept", block_out, {40'h0102030405, 88'd0});
    sync();

    // Reset in the middle of a block
    send_run(8'h50, 7);
    do_reset();
    @(negedge clk);
    check("t5_valid", {127'd0, block_valid}, 128'd0);
    check("t5_cnt", {112'd0, blk_cnt}, 128'd0);
    check("t5_block_out", block_out, 128'd0);
    sync();
    send_run(8'h60, 16);
    @(negedge clk);
    check("t5_post_block", block_out, 128'h606162636465666768696A6B6C6D6E6F);
    sync();

    // Sequence checker: 0xFF followed by 0x00 is a legal step
    do_reset();
    send_byte(8'hFE, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    @(negedge clk);
    check("t6_wrap_ok", {127'd0, seq_err}, 128'd0);
    sync();

    // Sequence checker: a skipped value sets a sticky error
    do_reset();
    send_byte(8'h10, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h13, 1'b0);
    @(negedge clk);
`ifdef SEQ_CHECK_EN
    check("t6_err_set", {127'd0, seq_err}, 128'd1);
`else
    check("t6_err_tied", {127'd0, seq_err}, 128'd0);
`endif
    sync();
    send_byte(8'h14, 1'b0);
    send_byte(8'h15, 1'b0);
    @(negedge clk);
`ifdef SEQ_CHECK_EN
    check("t6_err_sticky", {127'd0, seq_err}, 128'd1);
`else
    check("t6_err_tied2", {127'd0, seq_err}, 128'd0);
`endif
    sync();
    do_reset();
    @(negedge clk);
    check("t6_err_cleared", {127'd0, seq_err}, 128'd0);
    sync();

    // Randomized traffic. A pending sample is held until it is accepted.
    nb = 8'h00;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = sample_valid && sample_ready;
      sync();
      if (c == 700) begin
        do_reset();
        acc = 0;
      end
      if (acc) nb = 8'(sample_in + 8'd1);
      if (!sample_valid || acc) begin
        sample_valid = ($urandom_range(0, 3) != 0);
        sample_in    = ($urandom_range(0, 59) == 0) ? 8'($urandom_range(0, 255)) : nb;
      end
      flush       = ($urandom_range(0, 11) == 0);
      block_ready = ($urandom_range(0, 3) != 0);
    end
    sample_valid = 1'b0;
    flush        = 1'b0;
    block_ready  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
